nr_fetch_sequencer: RTL and testbench

//   Instruction-fetch sequencer for the nanoRisk core; the consuming end of the

---
 rtl/nr_pkg.sv | 11 +
 rtl/nr_skid_buf.sv | 58 +++++
 rtl/nr_fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_nr_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nr_pkg.sv
// Shared width defaults, reset address and FSM encoding for the nanoRisk fetch path.
package nr_pkg;

  localparam int         PC_W_DEF     = 8;
  localparam int         INSTR_W_DEF  = 8;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/nr_skid_buf.sv
// One-entry {pc, instr} holding buffer with valid/ready on both sides and a flush.
module nr_skid_buf
  import nr_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // A pop and a push may happen in the same cycle.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/nr_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency imem reads and
// presents {pc, instr} to decode from a registered stage backed by a skid buffer.
module nr_fetch_sequencer
  import nr_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch,
  input  logic               jump,
  input  logic [PC_W-1:0]    target,
  input  logic               halt,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  logic [0:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;

  logic               redirect, issue, out_load;
  logic [1:0]         held;
  logic               skid_in_valid, skid_in_ready, skid_out_valid;
  logic [PC_W-1:0]    skid_out_pc;
  logic [INSTR_W-1:0] skid_out_instr;

  assign redirect = branch | jump;
  assign out_load = ~out_valid_q | if_ready;

  // Words still held after this edge if decode stalls; a read issued now lands one edge later.
  assign held  = 2'(out_valid_q) + 2'(skid_out_valid) + 2'(inflight_q) - 2'(out_valid_q & if_ready);
  assign issue = ~rst & (state_q == ST_RUN) & ~redirect & ~halt & skid_in_ready & (held < 2'd2);

  assign skid_in_valid = inflight_q & (skid_out_valid | ~out_load);

  nr_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_pc     (inflight_pc_q),
    .in_instr  (imem_data),
    .out_valid (skid_out_valid),
    .out_ready (out_load),
    .out_pc    (skid_out_pc),
    .out_instr (skid_out_instr)
  );

  // A redirect kills the in-flight read (inflight_d stays 0) and empties both holding stages.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    if (redirect) begin
      state_d     = ST_RUN;
      pc_d        = target;
      out_valid_d = 1'b0;
    end else begin
      if (halt) state_d = ST_HALTED;
      if (issue) pc_d = pc_q + PC_W'(1);
      if (out_load) begin
        if (skid_out_valid) begin
          out_valid_d = 1'b1;
          out_pc_d    = skid_out_pc;
          out_instr_d = skid_out_instr;
        end else if (inflight_q) begin
          out_valid_d = 1'b1;
          out_pc_d    = inflight_pc_q;
          out_instr_d = imem_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
    end
  end

  assign imem_rd   = issue;
  assign imem_addr = pc_q;
  assign if_valid  = out_valid_q;
  assign if_pc     = out_pc_q;
  assign if_instr  = out_instr_q;

endmodule

// File: tb/tb_nr_fetch_sequencer.sv
// Directed bench for nr_fetch_sequencer: default instance plus a RESET_PC=8'hFE instance.
module tb_nr_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, branch, jump, halt, ifReady;
  logic [7:0] target;
  logic       imemRd, ifValid;
  logic [7:0] imemAddr, ifPc, ifInstr;
  logic [7:0] imemData = 8'h00;

  logic       rstFe, ifReadyFe;
  logic       imemRdFe, ifValidFe;
  logic [7:0] imemAddrFe, ifPcFe, ifInstrFe;
  logic [7:0] imemDataFe = 8'h00;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] expPc;

  nr_fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .branch    (branch),
    .jump      (jump),
    .target    (target),
    .halt      (halt),
    .imem_rd   (imemRd),
    .imem_addr (imemAddr),
    .imem_data (imemData),
    .if_valid  (ifValid),
    .if_ready  (ifReady),
    .if_pc     (ifPc),
    .if_instr  (ifInstr)
  );

  nr_fetch_sequencer #(.RESET_PC(8'hFE)) dut_fe (
    .clk       (clk),
    .rst       (rstFe),
    .branch    (1'b0),
    .jump      (1'b0),
    .target    (8'h00),
    .halt      (1'b0),
    .imem_rd   (imemRdFe),
    .imem_addr (imemAddrFe),
    .imem_data (imemDataFe),
    .if_valid  (ifValidFe),
    .if_ready  (ifReadyFe),
    .if_pc     (ifPcFe),
    .if_instr  (ifInstrFe)
  );

  function automatic logic [7:0] memF(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // Synchronous instruction memories: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imemRd) imemData <= memF(imemAddr);
    if (imemRdFe) imemDataFe <= memF(imemAddrFe);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic j, input logic [7:0] tgt,
                               input logic h, input logic rdy);
    @(posedge clk);
    #1;
    branch  = b;
    jump    = j;
    target  = tgt;
    halt    = h;
    ifReady = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; rstFe = 1'b1;
    branch = 1'b0; jump = 1'b0; halt = 1'b0; target = 8'h00;
    ifReady = 1'b0; ifReadyFe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset if_valid", 32'(ifValid), 32'd0);
    checkOutput("reset if_pc", 32'(ifPc), 32'd0);
    checkOutput("reset if_instr", 32'(ifInstr), 32'd0);
    checkOutput("reset imem_rd", 32'(imemRd), 32'd0);

    rst = 1'b0; ifReady = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput($sformatf("stream rd c%0d", c), 32'(imemRd), 32'd1);
      checkOutput($sformatf("stream addr c%0d", c), 32'(imemAddr), 32'(c));
      checkOutput($sformatf("stream valid c%0d", c), 32'(ifValid), 32'(c >= 2));
      if (c >= 2) begin
        checkOutput($sformatf("stream pc c%0d", c), 32'(ifPc), 32'(c - 2));
        checkOutput($sformatf("stream instr c%0d", c), 32'(ifInstr), 32'(memF(8'(c - 2))));
      end
    end

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("stall valid", 32'(ifValid), 32'd1);
      checkOutput("stall pc", 32'(ifPc), 32'h03);
      checkOutput("stall instr", 32'(ifInstr), 32'(memF(8'h03)));
      checkOutput("stall rd", 32'(imemRd), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("unstall pc", 32'(ifPc), 32'h03);
    checkOutput("unstall addr", 32'(imemAddr), 32'h05);
    checkOutput("unstall rd", 32'(imemRd), 32'd1);

    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
    checkOutput("skid pc", 32'(ifPc), 32'h04);
    checkOutput("skid instr", 32'(ifInstr), 32'(memF(8'h04)));
    checkOutput("jump rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("jump flush valid", 32'(ifValid), 32'd0);
    checkOutput("jump addr", 32'(imemAddr), 32'h40);
    checkOutput("jump rd next", 32'(imemRd), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("jump gap valid", 32'(ifValid), 32'd0);
    checkOutput("jump addr2", 32'(imemAddr), 32'h41);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("jump tgt valid", 32'(ifValid), 32'd1);
    checkOutput("jump tgt pc", 32'(ifPc), 32'h40);
    checkOutput("jump tgt instr", 32'(ifInstr), 32'(memF(8'h40)));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("jump tgt+1 pc", 32'(ifPc), 32'h41);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bp pc", 32'(ifPc), 32'h42);
    checkOutput("bp rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    checkOutput("branch held pc", 32'(ifPc), 32'h42);
    checkOutput("branch rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("branch flush valid", 32'(ifValid), 32'd0);
    checkOutput("branch addr", 32'(imemAddr), 32'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("branch gap valid", 32'(ifValid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("branch tgt valid", 32'(ifValid), 32'd1);
    checkOutput("branch tgt pc", 32'(ifPc), 32'h10);
    checkOutput("branch tgt instr", 32'(ifInstr), 32'(memF(8'h10)));

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("halt rd", 32'(imemRd), 32'd0);
    checkOutput("halt pc", 32'(ifPc), 32'h11);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput($sformatf("halted rd k%0d", k), 32'(imemRd), 32'd0);
      checkOutput($sformatf("halted valid k%0d", k), 32'(ifValid), 32'(k == 0));
      if (k == 0) checkOutput("halted last pc", 32'(ifPc), 32'h12);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("halt sticky rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h20, 1'b0, 1'b1);
    checkOutput("resume branch rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("resume rd", 32'(imemRd), 32'd1);
    checkOutput("resume addr", 32'(imemAddr), 32'h20);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("resume addr2", 32'(imemAddr), 32'h21);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("resume pc", 32'(ifPc), 32'h20);
    checkOutput("resume valid", 32'(ifValid), 32'd1);

    applyStimulus(1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
    checkOutput("both rd", 32'(imemRd), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("both addr", 32'(imemAddr), 32'h80);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("both pc", 32'(ifPc), 32'h80);

    // Wrap-around instance starting at 8'hFE.
    @(posedge clk);
    #1;
    rstFe = 1'b0; ifReadyFe = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
      end
      expPc = 8'hFE + 8'(c);
      checkOutput($sformatf("wrap addr c%0d", c), 32'(imemAddrFe), 32'(expPc));
      checkOutput($sformatf("wrap valid c%0d", c), 32'(ifValidFe), 32'(c >= 2));
      if (c >= 2) begin
        expPc = 8'hFE + 8'(c - 2);
        checkOutput($sformatf("wrap pc c%0d", c), 32'(ifPcFe), 32'(expPc));
        checkOutput($sformatf("wrap instr c%0d", c), 32'(ifInstrFe), 32'(memF(expPc)));
      end
    end
    @(posedge clk);
    #1;
    ifReadyFe = 1'b0;
    #1;
    checkOutput("fe stall pc", 32'(ifPcFe), 32'h02);
    checkOutput("fe stall rd", 32'(imemRdFe), 32'd0);
    @(posedge clk);
    #1;
    rstFe = 1'b1;
    #1;
    checkOutput("fe rst rd", 32'(imemRdFe), 32'd0);
    @(posedge clk);
    #1;
    rstFe = 1'b0; ifReadyFe = 1'b1;
    #1;
    checkOutput("fe post-rst valid", 32'(ifValidFe), 32'd0);
    checkOutput("fe post-rst pc", 32'(ifPcFe), 32'd0);
    checkOutput("fe post-rst addr", 32'(imemAddrFe), 32'hFE);
    checkOutput("fe post-rst rd", 32'(imemRdFe), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("fe restart gap", 32'(ifValidFe), 32'd0);
    @(posedge clk);
    #2;
    checkOutput("fe restart valid", 32'(ifValidFe), 32'd1);
    checkOutput("fe restart pc", 32'(ifPcFe), 32'hFE);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
